pwm_deadtime_array: RTL

- Multi-channel sine-triangle PWM modulator with complementary gate outputs and a runtime-programmable deadtime.
- Per channel: compare signed sine sample vs. shared triangle carrier; drive hi/lo gate pair with guaranteed both-off interval; three-level signed output.
- Adds over the single-channel generator: NCH channels, run-time deadtime with sync-strobed shadow load, enable gating, latched fault shutdown.
- Sits between the DDS sine/triangle generators and the FPGA gate-drive pins.

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_dt_channel.sv | 107 ++++++++++
 rtl/pwm_deadtime_array.sv | 83 ++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared definitions for the multi-channel deadtime PWM modulator:
//   - gate FSM state encodings (OFF, DEAD, HI, LO)
//   - width of the signed three-level output
//   - default deadtime after reset
//   - helper that builds the signed level constant
package pwm_pkg;

  localparam int LEVEL_W      = 4;
  localparam int DT_RESET_DEF = 5;

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_DEAD = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_LO   = 2'd3;

  // Two's-complement +mag or -mag in LEVEL_W bits.
  function automatic logic [LEVEL_W-1:0] level_of(input logic neg, input int mag);
    logic [LEVEL_W-1:0] mag_v;
    mag_v = LEVEL_W'(mag);
    return neg ? (~mag_v + 1'b1) : mag_v;
  endfunction

endpackage

// File: rtl/pwm_dt_channel.sv
// pwm_dt_channel
// One PWM channel: sine-vs-carrier compare, complementary gate FSM with
// deadtime, sign-change blanking counter and three-level output.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   run          channel may drive; low forces OFF and clears counters
//   dt_act       active deadtime in cycles (0 = direct switching)
//   sine         signed sample for this channel
//   carrier      signed triangle carrier (one bit wider than sine)
//   pwm_hi/lo    complementary gate outputs
//   level        signed three-level output (+mag, 0, -mag)
//   dt_active    gate deadtime or sign blanking in progress
module pwm_dt_channel
  import pwm_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DT_W      = 8,
  parameter int LEVEL_MAG = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [DT_W-1:0]    dt_act,
  input  logic [DATA_W-1:0]  sine,
  input  logic [DATA_W:0]    carrier,
  output logic               pwm_hi,
  output logic               pwm_lo,
  output logic [LEVEL_W-1:0] level,
  output logic               dt_active
);

  logic             cmp;
  logic             dt_zero;
  logic             sine_neg;
  logic [1:0]       state, state_n;
  logic             target, target_n;
  logic [DT_W-1:0]  cnt, cnt_n;
  logic [DT_W-1:0]  scnt;
  logic             sign_r;
  logic             start;

  assign sine_neg = sine[DATA_W-1];
  assign cmp      = $signed({sine_neg, sine}) >= $signed(carrier);
  assign dt_zero  = (dt_act == '0);

  // A new interval starts when leaving OFF, when the driven side no longer
  // matches the compare, or when a pending target is contradicted (restart).
  always_comb begin
    state_n  = state;
    target_n = target;
    cnt_n    = cnt;
    start    = (state == ST_OFF) ||
               (state == ST_HI   && !cmp) ||
               (state == ST_LO   &&  cmp) ||
               (state == ST_DEAD && (cmp != target));
    if (start) begin
      target_n = cmp;
      if (dt_zero) begin
        state_n = cmp ? ST_HI : ST_LO;
        cnt_n   = '0;
      end else begin
        state_n = ST_DEAD;
        cnt_n   = dt_act;
      end
    end else if (state == ST_DEAD) begin
      if (cnt <= DT_W'(1)) begin
        state_n = target ? ST_HI : ST_LO;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt - 1'b1;
      end
    end
  end

  // Gate FSM and sign blanking; sign_r keeps tracking while stopped so a
  // restart does not see a stale sign change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_OFF;
      target <= 1'b0;
      cnt    <= '0;
      scnt   <= '0;
      sign_r <= 1'b0;
    end else if (!run) begin
      state  <= ST_OFF;
      target <= 1'b0;
      cnt    <= '0;
      scnt   <= '0;
      sign_r <= sine_neg;
    end else begin
      state  <= state_n;
      target <= target_n;
      cnt    <= cnt_n;
      sign_r <= sine_neg;
      if (sine_neg != sign_r)
        scnt <= dt_act;
      else if (scnt != '0)
        scnt <= scnt - 1'b1;
    end
  end

  assign pwm_hi    = (state == ST_HI);
  assign pwm_lo    = (state == ST_LO);
  assign level     = (pwm_hi && scnt == '0) ? level_of(sign_r, LEVEL_MAG) : '0;
  assign dt_active = (state == ST_DEAD) || (scnt != '0);

endmodule

// File: rtl/pwm_deadtime_array.sv
// pwm_deadtime_array
// NCH-channel sine-triangle PWM with complementary gates, programmable
// deadtime (shadow-loaded on dt_load), enable gating and latched fault.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   enable         global run enable
//   dt_cycles      requested deadtime; copied to dt_act when dt_load=1
//   sine_in        NCH signed samples, channel i at [i*DATA_W +: DATA_W]
//   carrier_in     shared signed triangle carrier
//   fault          external fault level, forces all channels OFF
//   fault_clr      clears the fault latch when fault is low
//   pwm_hi/pwm_lo  gate outputs per channel
//   level_out      signed 4-bit three-level output per channel
//   dt_active      channel in deadtime or sign blanking
//   fault_latched  sticky fault indicator
module pwm_deadtime_array
  import pwm_pkg::*;
#(
  parameter int NCH       = 3,
  parameter int DATA_W    = 16,
  parameter int DT_W      = 8,
  parameter int DT_RESET  = DT_RESET_DEF,
  parameter int LEVEL_MAG = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [DT_W-1:0]         dt_cycles,
  input  logic                    dt_load,
  input  logic [NCH*DATA_W-1:0]   sine_in,
  input  logic [DATA_W:0]         carrier_in,
  input  logic                    fault,
  input  logic                    fault_clr,
  output logic [NCH-1:0]          pwm_hi,
  output logic [NCH-1:0]          pwm_lo,
  output logic [NCH*LEVEL_W-1:0]  level_out,
  output logic [NCH-1:0]          dt_active,
  output logic                    fault_latched
);

  logic [DT_W-1:0] dt_act;
  logic            run;

  // Active deadtime; intervals already counting keep their own copy.
  always_ff @(posedge clk) begin
    if (reset)
      dt_act <= DT_W'(DT_RESET);
    else if (dt_load)
      dt_act <= dt_cycles;
  end

  // Fault latch: set by fault, cleared only when fault is already gone.
  always_ff @(posedge clk) begin
    if (reset)
      fault_latched <= 1'b0;
    else if (fault)
      fault_latched <= 1'b1;
    else if (fault_clr)
      fault_latched <= 1'b0;
  end

  assign run = enable && !fault && !fault_latched;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_dt_channel #(
      .DATA_W    (DATA_W),
      .DT_W      (DT_W),
      .LEVEL_MAG (LEVEL_MAG)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
      .dt_act    (dt_act),
      .sine      (sine_in[i*DATA_W +: DATA_W]),
      .carrier   (carrier_in),
      .pwm_hi    (pwm_hi[i]),
      .pwm_lo    (pwm_lo[i]),
      .level     (level_out[i*LEVEL_W +: LEVEL_W]),
      .dt_active (dt_active[i])
    );
  end

endmodule
